spram_stream_reader: RTL and testbench
======================================

// Module: spram_stream_reader
// PURPOSE
// Read-side engine for a single-port RAM bank: accepts (start address, length) commands over valid/ready,
// issues reads on the shared RAM port through a req/gnt arbiter, and returns the words as a valid/ready
// stream with last marking. A 2-entry output buffer absorbs the 1-cycle RAM read latency and downstream
// back-pressure at full throughput. Pairs with the bank writer on the same RAM port.
// PARAMETERS
// DATA_WIDTH  8                      width of one RAM word / stream beat
// RAM_DEPTH   32                     number of RAM words (any value >= 2)
// ADDR_WIDTH  $clog2(RAM_DEPTH)      RAM address width
// LEN_WIDTH   ADDR_WIDTH+1           command length width (max len = RAM_DEPTH)
// PORTS
// clk        in   1           clock
// rst_n      in   1           reset, asynchronous, active-low
// cmd_addr   in   ADDR_WIDTH  start address of burst
// cmd_len    in   LEN_WIDTH   number of words to read (0 legal)
// cmd_valid  in   1           command valid
// cmd_ready  out  1           command accepted when valid&ready
// ram_req    out  1           read request to RAM port arbiter
// ram_gnt    in   1           arbiter grant; read executes on req&gnt
// ram_addr   out  ADDR_WIDTH  read address, registered
// ram_rdata  in   DATA_WIDTH  read data, valid the cycle after req&gnt
// out_data   out  DATA_WIDTH  stream data (buffer head)
// out_valid  out  1           stream valid
// out_ready  in   1           stream ready
// out_last   out  1           final beat of current burst
// busy       out  1           command in progress
// BEHAVIOUR
// - Reset: state IDLE, ram_addr=0, remaining=0, inflight=0, buffer empty; out_valid=0, out_data=0,
//   out_last=0, ram_req=0, busy=0, cmd_ready=1. Reset mid-burst drops all pending/buffered beats.
// - FSM IDLE -> READ on cmd handshake with cmd_len!=0 (load ram_addr=cmd_addr, remaining=cmd_len);
//   cmd_len==0: handshake accepted, stays IDLE, no RAM access, no beat.
//   READ -> DRAIN on the grant that issues the final word (remaining 1->0).
//   DRAIN -> IDLE when inflight==0 and buffer empty after the last pop (last beat handshake).
// - cmd_ready = (state==IDLE); busy = (state!=IDLE).
// - ram_req = (state==READ) & (remaining!=0) & (count + inflight - pop < 2), pop = out_valid&out_ready.
//   Once raised, ram_req stays high with ram_addr stable until ram_gnt (credit cannot shrink while waiting).
// - On req&gnt: ram_addr <= (ram_addr==RAM_DEPTH-1) ? 0 : ram_addr+1; remaining--; inflight<=1.
//   Next cycle ram_rdata written into buffer tail with last flag = (this was final word).
// - Buffer: 2-entry FIFO; out_valid = count!=0; out_data/out_last = head entry. Push and pop in same
//   cycle allowed (count unchanged). Never overflows by credit rule; entries are never dropped or duplicated.
// - Stream rules: out_data/out_last stable while out_valid&!out_ready; out_last high on exactly one beat per burst.
// - Latency: first out_valid 2 cycles after first grant; first grant no earlier than cycle after cmd handshake.
//   Sustained 1 beat/cycle with ram_gnt=1 and out_ready=1.
// - New command accepted only in IDLE; cmd_valid during busy is held off (cmd_ready=0).
// TESTING
// 1. RAM[i]=0x10+i, cmd addr=4 len=3, gnt=1, ready=1 -> beats 0x14,0x15,0x16 on consecutive cycles, last on 0x16.
// 2. cmd addr=30 len=4, RAM_DEPTH=32 -> ram_addr sequence 30,31,0,1; beats RAM[30],RAM[31],RAM[0],RAM[1].
// 3. len=8, out_ready=0 -> exactly 2 grants then ram_req=0, out_valid held with stable data; release -> all 8 in order.
// 4. len=16, ram_gnt random 50% -> ram_addr stable whenever req&!gnt; output sequence exact, no gaps in data.
// 5. cmd len=0 -> handshake completes, no ram_req, no out_valid, cmd_ready=1 next cycle.
// 6. rst_n low mid-burst (after 3 of 8 beats) -> all outputs at reset values; following cmd addr=0 len=2 correct.

Source files
------------

// File: rtl/spram_stream_reader.sv
// spram_stream_reader
//   Read engine for one single-port RAM bank. It takes (start address, length)
//   commands, reads the words through the shared RAM port's req/gnt arbiter, and
//   returns them as a valid/ready stream. The last beat of each burst is marked.
//   A 2-entry buffer absorbs the 1-cycle RAM read latency and downstream stalls.
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   cmd_addr/len/valid     burst command (len 0 is accepted and ignored)
//   cmd_ready              high only when idle
//   ram_req/gnt/addr       read request; a read executes on req & gnt
//   ram_rdata              read data, valid the cycle after req & gnt
//   out_data/valid/last    output stream (buffer head)
//   out_ready              downstream ready
//   busy                   a command is in progress
module spram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  ram_req,
  input  logic                  ram_gnt,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q;

  logic                  cmd_fire, gnt_fire, pop, push, final_word;
  logic [2:0]            occupancy;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign gnt_fire   = ram_req & ram_gnt;
  assign pop        = out_valid & out_ready;
  assign push       = inflight_q;
  assign final_word = (remaining_q == LEN_WIDTH'(1));

  assign ram_addr  = addr_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  // The head slot keeps stale flags after it drains, so gate last with valid.
  assign out_last  = out_valid & buf_last_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire && cmd_len != '0) state_d = READ;
      READ:    if (gnt_fire && final_word)    state_d = DRAIN;
      DRAIN:   if (pop && out_last)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The credit check counts the entry that will hold each word after
  // this cycle's push/pop, so an issued read always has room in the buffer.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    ram_req   = (state_q == READ) && (remaining_q != '0) && (occupancy < 3'd2);
  end

  // Address / length / in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (cmd_fire && cmd_len != '0) begin
        addr_q      <= cmd_addr;
        remaining_q <= cmd_len;
      end else if (gnt_fire) begin
        addr_q      <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      inflight_q      <= gnt_fire;
      inflight_last_q <= gnt_fire & final_word;
    end
  end

  // 2-entry output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= ram_rdata;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_stream_reader.sv
module tb_spram_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  spram_stream_reader #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behaviour: data for an accepted read appears the following cycle
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (rst_n && ram_req && ram_gnt) ram_rdata <= mem[ram_addr];

  int tests, fails;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the expected beat list of all accepted commands
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         expq[$];
  int            exp_rem, issued, popped;
  logic [AW-1:0] exp_addr;
  logic          prev_req, prev_gnt;
  logic [AW-1:0] prev_addr;
  int            pop_cyc[$];
  logic [DW-1:0] pop_dat[$];
  logic          pop_last[$];
  int            gnt_cyc[$];
  logic [AW-1:0] gnt_addr[$];
  int            hs_cyc;
  int            pct_gnt, pct_ready;

  // Inputs change at posedge+1, so at negedge everything is settled for the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      chk("busy", busy, expq.size() != 0);
      chk("cmd_ready", cmd_ready, expq.size() == 0);
      chk("req_allowed", ram_req && exp_rem == 0, 0);
      chk("credit", (issued - popped) <= 2, 1);
      if (prev_req && !prev_gnt) begin
        chk("req_hold", ram_req, 1);
        chk("addr_hold", ram_addr, prev_addr);
      end
      if (ram_req) chk("ram_addr", ram_addr, exp_addr);
      if (out_valid) begin
        chk("valid_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          chk("out_data", out_data, expq[0].d);
          chk("out_last", out_last, expq[0].l);
        end
      end else begin
        chk("last_without_valid", out_last, 0);
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc); pop_dat.push_back(out_data); pop_last.push_back(out_last);
        if (expq.size() != 0) void'(expq.pop_front());
        popped++;
      end
      if (ram_req && ram_gnt) begin
        gnt_cyc.push_back(cyc); gnt_addr.push_back(ram_addr);
        exp_addr = AW'((int'(exp_addr) + 1) % DEPTH);
        if (exp_rem > 0) exp_rem--;
        issued++;
      end
      if (cmd_valid && cmd_ready) begin
        hs_cyc = cyc;
        for (int i = 0; i < int'(cmd_len); i++)
          expq.push_back('{d: mem[(int'(cmd_addr) + i) % DEPTH], l: (i == int'(cmd_len) - 1)});
        if (cmd_len != 0) begin
          exp_addr = cmd_addr;
          exp_rem  = int'(cmd_len);
        end
      end
      prev_req = ram_req; prev_gnt = ram_gnt; prev_addr = ram_addr;
    end
  end

  // Random grant / ready generator
  initial begin
    ram_gnt = 1'b0; out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ram_gnt   = ($urandom_range(99) < pct_gnt);
      out_ready = ($urandom_range(99) < pct_ready);
    end
  end

  task automatic clear_logs();
    pop_cyc.delete(); pop_dat.delete(); pop_last.delete();
    gnt_cyc.delete(); gnt_addr.delete();
  endtask

  task automatic send_cmd(input int a, input int l);
    int n = 0;
    cmd_addr = AW'(a); cmd_len = LW'(l); cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk);
    while ((busy || expq.size() != 0) && n < max) begin @(negedge clk); n++; end
    chk("idle_reached", busy || expq.size() != 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_addr"},  ram_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_last"},  out_last, 0);
    chk({tag, "_ram_req"},   ram_req, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic reset_model();
    expq.delete(); exp_rem = 0; issued = 0; popped = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    pct_gnt = 100; pct_ready = 100;
    reset_model();
    fill_ramp();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic burst: 0x14,0x15,0x16 back to back, last on the third
    clear_logs(); send_cmd(4, 3); wait_idle(50);
    chk("t1_beats", pop_dat.size(), 3);
    if (pop_dat.size() == 3 && gnt_cyc.size() == 3) begin
      chk("t1_d0", pop_dat[0], 8'h14); chk("t1_d1", pop_dat[1], 8'h15); chk("t1_d2", pop_dat[2], 8'h16);
      chk("t1_l0", pop_last[0], 0); chk("t1_l1", pop_last[1], 0); chk("t1_l2", pop_last[2], 1);
      chk("t1_gap01", pop_cyc[1] - pop_cyc[0], 1); chk("t1_gap12", pop_cyc[2] - pop_cyc[1], 1);
      chk("t1_cmd_to_gnt", gnt_cyc[0] - hs_cyc, 1);
      chk("t1_gnt_to_valid", pop_cyc[0] - gnt_cyc[0], 2);
    end

    // Address wrap
    clear_logs(); send_cmd(30, 4); wait_idle(50);
    chk("t2_grants", gnt_addr.size(), 4);
    if (gnt_addr.size() == 4 && pop_dat.size() == 4) begin
      chk("t2_a0", gnt_addr[0], 30); chk("t2_a1", gnt_addr[1], 31);
      chk("t2_a2", gnt_addr[2], 0);  chk("t2_a3", gnt_addr[3], 1);
      chk("t2_d0", pop_dat[0], 8'h2E); chk("t2_d1", pop_dat[1], 8'h2F);
      chk("t2_d2", pop_dat[2], 8'h10); chk("t2_d3", pop_dat[3], 8'h11);
    end

    // Back-pressure: only two reads may be outstanding
    pct_ready = 0;
    clear_logs(); send_cmd(8, 8);
    repeat (12) @(negedge clk);
    chk("t3_grants", gnt_cyc.size(), 2);
    chk("t3_req_low", ram_req, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, 8'h18);
    pct_ready = 100;
    wait_idle(100);
    chk("t3_beats", pop_dat.size(), 8);
    if (pop_dat.size() == 8) begin
      chk("t3_d7", pop_dat[7], 8'h1F); chk("t3_l7", pop_last[7], 1);
    end

    // Random grant at 50%
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(255));
    pct_gnt = 50;
    clear_logs(); send_cmd($urandom_range(DEPTH - 1), 16); wait_idle(400);
    chk("t4_beats", pop_dat.size(), 16);
    pct_gnt = 100;

    // Zero length: accepted, no RAM access, no beat
    clear_logs(); send_cmd(7, 0);
    @(negedge clk);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t5_grants", gnt_cyc.size(), 0);
    chk("t5_beats", pop_dat.size(), 0);
    @(posedge clk); #1;

    // Reset in the middle of a burst
    fill_ramp();
    clear_logs(); send_cmd(5, 8);
    n = 0;
    while (pop_dat.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
    chk("t6_three_beats", pop_dat.size(), 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    reset_model();
    #1 check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs(); send_cmd(0, 2); wait_idle(50);
    chk("t6_beats", pop_dat.size(), 2);
    if (pop_dat.size() == 2) begin
      chk("t6_d0", pop_dat[0], 8'h10); chk("t6_d1", pop_dat[1], 8'h11);
      chk("t6_l0", pop_last[0], 0);    chk("t6_l1", pop_last[1], 1);
    end

    // Random traffic; odd rounds issue the next command while still busy
    for (int r = 0; r < 12; r++) begin
      if (r % 2 == 0) begin
        wait_idle(1000);
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(255));
      end
      pct_gnt   = $urandom_range(30, 100);
      pct_ready = $urandom_range(30, 100);
      send_cmd($urandom_range(DEPTH - 1), $urandom_range(0, DEPTH));
    end
    wait_idle(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
